// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory req/gnt/rvalid channel plus the
// valid/ready channel towards decode. The master is the fetch unit.
interface instr_fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;
  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic             out_ready;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc,
    output mem_gnt, mem_rvalid, mem_rdata, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding req/gnt/rvalid fetches from the
// current PC into a small in-order {pc, instr} buffer drained by decode.
module instr_fetch_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   pc,
  output logic               pc_adv,
  input  logic               redirect,
  instr_fetch_unit_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] req_addr_r, req_addr_nxt_s;
  logic             mem_req_s, pc_adv_s, push_s, pop_s;
  logic [WIDTH-1:0] mem_addr_s;
  logic [CW-1:0]    count_r, remain_s;
  logic [PW-1:0]    rd_ptr_r, wr_ptr_r, rd_ptr_pop_s;
  logic [WIDTH-1:0] pc_mem_r    [DEPTH];
  logic [WIDTH-1:0] instr_mem_r [DEPTH];
  logic [WIDTH-1:0] head_pc_r, head_instr_r, head_pc_nxt_s, head_instr_nxt_s;
  logic             head_load_s;

  // Fetch sequencing: next state, request outputs and buffer push.
  always_comb begin
    state_nxt_s    = state_r;
    req_addr_nxt_s = req_addr_r;
    mem_req_s      = 1'b0;
    mem_addr_s     = {WIDTH{1'b0}};
    pc_adv_s       = 1'b0;
    push_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if ((count_r < CW'(DEPTH)) && !redirect) begin
          state_nxt_s    = REQ;
          req_addr_nxt_s = pc;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        mem_req_s  = 1'b1;
        mem_addr_s = req_addr_r;
        if (bus.mem_gnt) begin
          if (redirect) begin
            state_nxt_s = DROP;
          end else begin
            state_nxt_s = WAIT;
            pc_adv_s    = 1'b1;
          end
        end else if (redirect) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_nxt_s = IDLE;
          push_s      = !redirect;
        end else if (redirect) begin
          state_nxt_s = DROP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DROP: begin
        if (bus.mem_rvalid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Head register follows the oldest surviving entry; it holds when the buffer drains.
  always_comb begin
    pop_s            = (count_r != {CW{1'b0}}) && bus.out_ready;
    remain_s         = count_r - CW'(pop_s);
    rd_ptr_pop_s     = rd_ptr_r + PW'(pop_s);
    head_load_s      = 1'b0;
    head_pc_nxt_s    = head_pc_r;
    head_instr_nxt_s = head_instr_r;
    if (redirect) begin
      head_load_s = 1'b0;
    end else if (remain_s != {CW{1'b0}}) begin
      head_load_s      = 1'b1;
      head_pc_nxt_s    = pc_mem_r[rd_ptr_pop_s];
      head_instr_nxt_s = instr_mem_r[rd_ptr_pop_s];
    end else if (push_s) begin
      head_load_s      = 1'b1;
      head_pc_nxt_s    = req_addr_r;
      head_instr_nxt_s = bus.mem_rdata;
    end else begin
      head_load_s = 1'b0;
    end
  end

  // State, request address, buffer storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      req_addr_r   <= {WIDTH{1'b0}};
      count_r      <= {CW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      head_pc_r    <= {WIDTH{1'b0}};
      head_instr_r <= {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= {WIDTH{1'b0}};
        instr_mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_r    <= state_nxt_s;
      req_addr_r <= req_addr_nxt_s;
      if (redirect) begin
        count_r  <= {CW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
      end else begin
        count_r  <= count_r + CW'(push_s) - CW'(pop_s);
        rd_ptr_r <= rd_ptr_pop_s;
        if (push_s) begin
          pc_mem_r[wr_ptr_r]    <= req_addr_r;
          instr_mem_r[wr_ptr_r] <= bus.mem_rdata;
          wr_ptr_r              <= wr_ptr_r + PW'(1'b1);
        end
      end
      if (head_load_s) begin
        head_pc_r    <= head_pc_nxt_s;
        head_instr_r <= head_instr_nxt_s;
      end
    end
  end

  assign pc_adv        = pc_adv_s;
  assign bus.mem_req   = mem_req_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.out_valid = (count_r != {CW{1'b0}});
  assign bus.out_pc    = head_pc_r;
  assign bus.out_instr = head_instr_r;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change 1 time unit after the
// rising edge, outputs are compared on the falling edge.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_adv;
  logic        redirect;
  int          checks = 0;
  int          errors = 0;

  instr_fetch_unit_if #(.WIDTH(32)) bus ();

  instr_fetch_unit #(.WIDTH(32), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .pc_adv   (pc_adv),
    .redirect (redirect),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Two redirect cycles return the unit to IDLE with an empty buffer.
  task automatic quiesce();
    adv();
    redirect = 1'b1; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.out_ready = 1'b0;
    adv();
    adv();
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 32'h0; redirect = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; bus.out_ready = 1'b0;
    adv();
    adv();
    mid();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0b exp 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr got %h exp 0", bus.out_instr); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc got %h exp 0", bus.out_pc); end
    checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL rst_pc_adv got %0b exp 0", pc_adv); end
    adv();
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    pc = 32'h100;
    mid();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL t1_idle_req got %0b exp 0", bus.mem_req); end
    adv(); bus.mem_gnt = 1'b1;
    mid();
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL t1_req got %0b exp 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL t1_addr got %h exp 100", bus.mem_addr); end
    checks++; if (pc_adv !== 1'b1) begin errors++; $display("FAIL t1_pc_adv got %0b exp 1", pc_adv); end
    adv(); bus.mem_gnt = 1'b0;
    mid();
    checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL t1_pc_adv_wait got %0b exp 0", pc_adv); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL t1_req_wait got %0b exp 0", bus.mem_req); end
    adv(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00500093;
    mid();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %0b exp 0", bus.out_valid); end
    adv(); bus.mem_rvalid = 1'b0;
    mid();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %0b exp 1", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL t1_out_pc got %h exp 100", bus.out_pc); end
    checks++; if (bus.out_instr !== 32'h00500093) begin errors++; $display("FAIL t1_out_instr got %h exp 00500093", bus.out_instr); end
    quiesce();
  endtask

  task automatic test_slow_grant();
    pc = 32'h100;
    adv(); pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      mid();
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL t2_req_%0d got %0b exp 1", i, bus.mem_req); end
      checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL t2_addr_%0d got %h exp 100", i, bus.mem_addr); end
      checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL t2_pc_adv_%0d got %0b exp 0", i, pc_adv); end
      adv();
    end
    bus.mem_gnt = 1'b1;
    mid();
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL t2_addr_gnt got %h exp 100", bus.mem_addr); end
    checks++; if (pc_adv !== 1'b1) begin errors++; $display("FAIL t2_pc_adv_gnt got %0b exp 1", pc_adv); end
    adv(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00000011;
    mid();
    checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL t2_pc_adv_after got %0b exp 0", pc_adv); end
    adv(); bus.mem_rvalid = 1'b0;
    mid();
    checks++; if (bus.out_instr !== 32'h11) begin errors++; $display("FAIL t2_out_instr got %h exp 11", bus.out_instr); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL t2_out_pc got %h exp 100", bus.out_pc); end
    quiesce();
  endtask

  task automatic test_backpressure();
    pc = 32'h10; bus.out_ready = 1'b0;
    adv(); bus.mem_gnt = 1'b1;
    adv(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA;
    adv(); bus.mem_rvalid = 1'b0; pc = 32'h14;
    mid();
    checks++; if (bus.out_instr !== 32'hA) begin errors++; $display("FAIL t3_first got %h exp a", bus.out_instr); end
    adv(); bus.mem_gnt = 1'b1;
    adv(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hB;
    adv(); bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid();
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL t3_full_req_%0d got %0b exp 0", i, bus.mem_req); end
      checks++; if (bus.out_instr !== 32'hA) begin errors++; $display("FAIL t3_full_head_%0d got %h exp a", i, bus.out_instr); end
      adv();
    end
    bus.out_ready = 1'b1;
    mid();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL t3_pop_a_valid got %0b exp 1", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h10) begin errors++; $display("FAIL t3_pop_a_pc got %h exp 10", bus.out_pc); end
    adv(); pc = 32'h18;
    mid();
    checks++; if (bus.out_instr !== 32'hB) begin errors++; $display("FAIL t3_pop_b got %h exp b", bus.out_instr); end
    checks++; if (bus.out_pc !== 32'h14) begin errors++; $display("FAIL t3_pop_b_pc got %h exp 14", bus.out_pc); end
    adv(); bus.out_ready = 1'b0;
    mid();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t3_empty got %0b exp 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'hB) begin errors++; $display("FAIL t3_hold got %h exp b", bus.out_instr); end
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL t3_resume got %0b exp 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h18) begin errors++; $display("FAIL t3_resume_addr got %h exp 18", bus.mem_addr); end
    quiesce();
  endtask

  task automatic test_redirect_wait();
    pc = 32'h100;
    adv(); bus.mem_gnt = 1'b1;
    adv(); bus.mem_gnt = 1'b0; redirect = 1'b1; pc = 32'h200;
    adv(); redirect = 1'b0;
    mid();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL t4_drop_req got %0b exp 0", bus.mem_req); end
    adv(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD;
    mid();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL t4_drop_req2 got %0b exp 0", bus.mem_req); end
    adv(); bus.mem_rvalid = 1'b0;
    mid();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t4_discard got %0b exp 0", bus.out_valid); end
    adv();
    mid();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t4_discard2 got %0b exp 0", bus.out_valid); end
    checks++; if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL t4_new_addr got %h exp 200", bus.mem_addr); end
    quiesce();
  endtask

  task automatic test_redirect_push_pop();
    pc = 32'h300;
    adv(); bus.mem_gnt = 1'b1;
    adv(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111;
    adv(); bus.mem_rvalid = 1'b0; pc = 32'h304;
    adv(); bus.mem_gnt = 1'b1;
    adv(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h2222;
    redirect = 1'b1; bus.out_ready = 1'b1;
    mid();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL t5_count1 got %0b exp 1", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h1111) begin errors++; $display("FAIL t5_head got %h exp 1111", bus.out_instr); end
    adv(); redirect = 1'b0; bus.mem_rvalid = 1'b0; bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t5_flush_%0d got %0b exp 0", i, bus.out_valid); end
      checks++; if (bus.out_instr !== 32'h1111) begin errors++; $display("FAIL t5_no_leak_%0d got %h exp 1111", i, bus.out_instr); end
      adv();
    end
    redirect = 1'b1;
    adv();
    adv();
    redirect = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    pc = 32'h400;
    adv(); bus.mem_gnt = 1'b1;
    adv(); bus.mem_gnt = 1'b0; rst = 1'b1;
    mid();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL t6_req_in_rst got %0b exp 0", bus.mem_req); end
    adv();
    mid();
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL t6_instr_rst got %h exp 0", bus.out_instr); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL t6_pc_rst got %h exp 0", bus.out_pc); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL t6_addr_rst got %h exp 0", bus.mem_addr); end
    adv(); rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD;
    mid();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL t6_idle_req got %0b exp 0", bus.mem_req); end
    adv(); bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b1;
    mid();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t6_stale got %0b exp 0", bus.out_valid); end
    checks++; if (bus.mem_addr !== 32'h400) begin errors++; $display("FAIL t6_addr got %h exp 400", bus.mem_addr); end
    checks++; if (pc_adv !== 1'b1) begin errors++; $display("FAIL t6_pc_adv got %0b exp 1", pc_adv); end
    adv(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00A00113;
    adv(); bus.mem_rvalid = 1'b0;
    mid();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL t6_valid got %0b exp 1", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h00A00113) begin errors++; $display("FAIL t6_instr got %h exp 00a00113", bus.out_instr); end
    checks++; if (bus.out_pc !== 32'h400) begin errors++; $display("FAIL t6_pc got %h exp 400", bus.out_pc); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_slow_grant();
    test_backpressure();
    test_redirect_wait();
    test_redirect_push_pop();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
